sga_direction_sensor: RTL and testbench

Measures two ultrasonic sensors (left, right) for the Snake Game Arcade control unit and turns them into a 2-bit direction request. The control unit pulses `medir`, waits for `fim_inter`, then pulses `enable` to commit the result to `interface_direction`. The block sequences trigger pulses, times each echo and applies timeouts. It compares each echo width against a near-hand threshold.

---
 rtl/sga_direction_sensor.sv | 231 +++++++++++++++++++++++
 tb/tb_sga_direction_sensor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sga_direction_sensor.sv
// sga_direction_sensor
// Sequences the left and right ultrasonic sensors, times each echo against a
// near-hand threshold and reports a 2-bit {right_near, left_near} request.
// The control unit starts a measurement with medir, waits for fim_inter and
// commits the pending result to interface_direction with enable.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for medir
// TRIG_L | left trigger pulse, TRIGGER_CYCLES long
// WAIT_L | waiting for the synchronized left echo to rise (with timeout)
// MEAS_L | timing the left echo width (with timeout)
// GAP    | dead time so left-sensor ringing cannot reach the right sensor
// TRIG_R | right trigger pulse
// WAIT_R | waiting for the synchronized right echo to rise (with timeout)
// MEAS_R | timing the right echo width (with timeout)
// DONE   | result pending, fim_inter high; enable commits, medir restarts

module sga_direction_sensor #(
    parameter int TRIGGER_CYCLES      = 500,
    parameter int GAP_CYCLES          = 50000,
    parameter int ECHO_TIMEOUT_CYCLES = 1500000,
    parameter int THRESH_CYCLES       = 29000,
    parameter int CNT_W               = 21
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       medir,
    input  logic       clear,
    input  logic       enable,
    input  logic       echo_left,
    input  logic       echo_right,
    output logic       trigger_left,
    output logic       trigger_right,
    output logic       fim_inter,
    output logic [1:0] interface_direction,
    output logic       timeout,
    output logic [3:0] db_state
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        TRIG_L = 4'd1,
        WAIT_L = 4'd2,
        MEAS_L = 4'd3,
        GAP    = 4'd4,
        TRIG_R = 4'd5,
        WAIT_R = 4'd6,
        MEAS_R = 4'd7,
        DONE   = 4'd8
    } state_t;

    // Compare points are "last cycle" values because the counter starts at 0
    // on every state entry.
    localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(ECHO_TIMEOUT_CYCLES - 1);
    // The cycle that detected the rising echo in WAIT is part of the width,
    // so MEAS count + 1 is the echo width; near iff width < THRESH_CYCLES.
    localparam logic [CNT_W-1:0] NEAR_LIMIT = CNT_W'(THRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       sync_left;
    logic [1:0]       sync_right;
    logic             echo_left_s;
    logic             echo_right_s;
    logic             left_near;
    logic             right_near;

    // Two-flop synchronizers for the asynchronous echo inputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_left  <= 2'b00;
            sync_right <= 2'b00;
        end else begin
            sync_left  <= {sync_left[0], echo_left};
            sync_right <= {sync_right[0], echo_right};
        end
    end

    assign echo_left_s  = sync_left[1];
    assign echo_right_s = sync_right[1];

    // Saturating increment: the counter holds at all-ones instead of wrapping.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    assign db_state = state;

    // Measurement sequencer with registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            cnt                 <= '0;
            trigger_left        <= 1'b0;
            trigger_right       <= 1'b0;
            fim_inter           <= 1'b0;
            interface_direction <= 2'b00;
            timeout             <= 1'b0;
            left_near           <= 1'b0;
            right_near          <= 1'b0;
        end else if (clear) begin
            // Abort: committed direction and timeout flag are deliberately kept.
            state         <= IDLE;
            cnt           <= '0;
            trigger_left  <= 1'b0;
            trigger_right <= 1'b0;
            fim_inter     <= 1'b0;
            left_near     <= 1'b0;
            right_near    <= 1'b0;
        end else begin
            cnt <= cnt_inc;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (medir) begin
                        state        <= TRIG_L;
                        trigger_left <= 1'b1;
                        timeout      <= 1'b0;
                        left_near    <= 1'b0;
                        right_near   <= 1'b0;
                    end
                end

                TRIG_L: begin
                    if (cnt == TRIG_LAST) begin
                        state        <= WAIT_L;
                        trigger_left <= 1'b0;
                        cnt          <= '0;
                    end
                end

                WAIT_L: begin
                    if (echo_left_s) begin
                        state <= MEAS_L;
                        cnt   <= '0;
                    end else if (cnt >= TO_LAST) begin
                        state     <= GAP;
                        left_near <= 1'b0;
                        timeout   <= 1'b1;
                        cnt       <= '0;
                    end
                end

                MEAS_L: begin
                    if (!echo_left_s) begin
                        state     <= GAP;
                        left_near <= (cnt < NEAR_LIMIT);
                        cnt       <= '0;
                    end else if (cnt >= TO_LAST) begin
                        state     <= GAP;
                        left_near <= 1'b0;
                        timeout   <= 1'b1;
                        cnt       <= '0;
                    end
                end

                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state         <= TRIG_R;
                        trigger_right <= 1'b1;
                        cnt           <= '0;
                    end
                end

                TRIG_R: begin
                    if (cnt == TRIG_LAST) begin
                        state         <= WAIT_R;
                        trigger_right <= 1'b0;
                        cnt           <= '0;
                    end
                end

                WAIT_R: begin
                    if (echo_right_s) begin
                        state <= MEAS_R;
                        cnt   <= '0;
                    end else if (cnt >= TO_LAST) begin
                        state      <= DONE;
                        right_near <= 1'b0;
                        timeout    <= 1'b1;
                        fim_inter  <= 1'b1;
                        cnt        <= '0;
                    end
                end

                MEAS_R: begin
                    if (!echo_right_s) begin
                        state      <= DONE;
                        right_near <= (cnt < NEAR_LIMIT);
                        fim_inter  <= 1'b1;
                        cnt        <= '0;
                    end else if (cnt >= TO_LAST) begin
                        state      <= DONE;
                        right_near <= 1'b0;
                        timeout    <= 1'b1;
                        fim_inter  <= 1'b1;
                        cnt        <= '0;
                    end
                end

                DONE: begin
                    cnt <= '0;
                    // Commit uses the pre-restart pending bits when both arrive together.
                    if (enable) begin
                        interface_direction <= {right_near, left_near};
                    end
                    if (medir) begin
                        state        <= TRIG_L;
                        trigger_left <= 1'b1;
                        fim_inter    <= 1'b0;
                        timeout      <= 1'b0;
                        left_near    <= 1'b0;
                        right_near   <= 1'b0;
                    end
                end

                default: begin
                    state         <= IDLE;
                    cnt           <= '0;
                    trigger_left  <= 1'b0;
                    trigger_right <= 1'b0;
                    fim_inter     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sga_direction_sensor.sv
// Bench for sga_direction_sensor with small timing parameters. Echo stimulus
// is described as (delay after trigger fall, width) and the expected result is
// derived from those widths directly.
module tb_sga_direction_sensor;

    localparam int TRIG = 4;
    localparam int GAPC = 8;
    localparam int TO   = 100;
    localparam int TH   = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       medir = 1'b0;
    logic       clear = 1'b0;
    logic       enable = 1'b0;
    logic       echo_left = 1'b0;
    logic       echo_right = 1'b0;
    logic       trigger_left;
    logic       trigger_right;
    logic       fim_inter;
    logic [1:0] interface_direction;
    logic       timeout;
    logic [3:0] db_state;

    int total = 0;
    int bad   = 0;
    logic [1:0] cur_dir = 2'b00;

    sga_direction_sensor #(
        .TRIGGER_CYCLES(TRIG),
        .GAP_CYCLES(GAPC),
        .ECHO_TIMEOUT_CYCLES(TO),
        .THRESH_CYCLES(TH),
        .CNT_W(21)
    ) dut (
        .clock(clock),
        .reset(reset),
        .medir(medir),
        .clear(clear),
        .enable(enable),
        .echo_left(echo_left),
        .echo_right(echo_right),
        .trigger_left(trigger_left),
        .trigger_right(trigger_right),
        .fim_inter(fim_inter),
        .interface_direction(interface_direction),
        .timeout(timeout),
        .db_state(db_state)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: a sensor is near iff it echoed with width below threshold;
    // no echo or an echo longer than the timeout window counts as far + timeout.
    function automatic void model(input int d, input int w, output bit near, output bit to);
        if (d < 0 || w <= 0 || w > TO) begin
            near = 1'b0;
            to   = 1'b1;
        end else begin
            near = (w < TH);
            to   = 1'b0;
        end
    endfunction

    // Runs one measurement from a medir pulse until fim_inter (or abort in MEAS_R).
    task automatic run_meas(input int dl, input int wl, input int dr, input int wr,
                            input bit poke_medir, input bit abort_r,
                            output int trig_len, output int gap_len,
                            output int wait_l_len, output bit finished);
        int ls = -1;
        int rs = -1;
        bit prev_tl = 1'b0;
        bit prev_tr = 1'b0;
        trig_len = 0; gap_len = 0; wait_l_len = 0; finished = 1'b0;
        medir = 1'b1;
        tick();
        medir = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (trigger_left) trig_len++;
            if (db_state == 4'd4) gap_len++;
            if (db_state == 4'd2) wait_l_len++;
            if (prev_tl && !trigger_left && dl >= 0) ls = cyc + dl;
            if (prev_tr && !trigger_right && dr >= 0) rs = cyc + dr;
            prev_tl = trigger_left;
            prev_tr = trigger_right;
            echo_left  = (ls >= 0 && cyc >= ls && cyc < ls + wl);
            echo_right = (rs >= 0 && cyc >= rs && cyc < rs + wr);
            if (poke_medir) medir = (cyc == 1);
            if (abort_r && db_state == 4'd7) begin
                clear = 1'b1;
                medir = 1'b1;
                tick();
                clear = 1'b0;
                medir = 1'b0;
                break;
            end
            if (fim_inter) begin
                finished = 1'b1;
                break;
            end
            tick();
        end
        echo_left = 1'b0;
        echo_right = 1'b0;
        medir = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if ({trigger_left, trigger_right, fim_inter, interface_direction, timeout, db_state} !== 10'd0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got tl=%b tr=%b fim=%b dir=%b to=%b st=%0d want all 0",
                         i, trigger_left, trigger_right, fim_inter, interface_direction, timeout, db_state);
            end
        end
    endtask

    task automatic test_basic();
        int tl, gl, wl; bit fin;
        run_meas(3, 10, 2, 50, 1'b0, 1'b0, tl, gl, wl, fin);
        total++; if (fin !== 1'b1) begin bad++; $display("FAIL basic_done got %b want 1", fin); end
        total++; if (tl != TRIG) begin bad++; $display("FAIL basic_trig_len got %0d want %0d", tl, TRIG); end
        total++; if (gl != GAPC) begin bad++; $display("FAIL basic_gap_len got %0d want %0d", gl, GAPC); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL basic_timeout got %b want 0", timeout); end
        total++; if (interface_direction !== cur_dir) begin bad++; $display("FAIL basic_dir_held got %b want %b", interface_direction, cur_dir); end
        enable = 1'b1; tick(); enable = 1'b0;
        cur_dir = 2'b01;
        total++; if (interface_direction !== cur_dir) begin bad++; $display("FAIL basic_dir got %b want %b", interface_direction, cur_dir); end
        total++; if (fim_inter !== 1'b1) begin bad++; $display("FAIL basic_fim_hold got %b want 1", fim_inter); end
    endtask

    task automatic test_left_no_echo();
        int tl, gl, wl; bit fin;
        run_meas(-1, 0, 3, 5, 1'b0, 1'b0, tl, gl, wl, fin);
        total++; if (fin !== 1'b1) begin bad++; $display("FAIL noecho_done got %b want 1", fin); end
        total++; if (wl != TO) begin bad++; $display("FAIL noecho_wait_len got %0d want %0d", wl, TO); end
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL noecho_timeout got %b want 1", timeout); end
        enable = 1'b1; tick(); enable = 1'b0;
        cur_dir = 2'b10;
        total++; if (interface_direction !== cur_dir) begin bad++; $display("FAIL noecho_dir got %b want %b", interface_direction, cur_dir); end
    endtask

    task automatic test_left_stuck();
        int tl, gl, wl; bit fin;
        run_meas(2, 150, 4, 5, 1'b0, 1'b0, tl, gl, wl, fin);
        total++; if (fin !== 1'b1) begin bad++; $display("FAIL stuck_done got %b want 1", fin); end
        total++; if (gl != GAPC) begin bad++; $display("FAIL stuck_gap_len got %0d want %0d", gl, GAPC); end
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL stuck_timeout got %b want 1", timeout); end
        enable = 1'b1; tick(); enable = 1'b0;
        cur_dir = 2'b10;
        total++; if (interface_direction !== cur_dir) begin bad++; $display("FAIL stuck_dir got %b want %b", interface_direction, cur_dir); end
    endtask

    task automatic test_boundary();
        int tl, gl, wl; bit fin;
        run_meas(1, 19, 1, 20, 1'b0, 1'b0, tl, gl, wl, fin);
        enable = 1'b1; tick(); enable = 1'b0;
        cur_dir = 2'b01;
        total++; if (interface_direction !== cur_dir || timeout !== 1'b0) begin bad++; $display("FAIL bound_19_20 got dir=%b to=%b want dir=%b to=0", interface_direction, timeout, cur_dir); end
        run_meas(1, 20, 1, 19, 1'b0, 1'b0, tl, gl, wl, fin);
        enable = 1'b1; tick(); enable = 1'b0;
        cur_dir = 2'b10;
        total++; if (interface_direction !== cur_dir || timeout !== 1'b0) begin bad++; $display("FAIL bound_20_19 got dir=%b to=%b want dir=%b to=0", interface_direction, timeout, cur_dir); end
    endtask

    task automatic test_enable_medir();
        int tl, gl, wl; bit fin;
        run_meas(1, 5, 1, 5, 1'b0, 1'b0, tl, gl, wl, fin);
        total++; if (fin !== 1'b1 || interface_direction !== cur_dir) begin bad++; $display("FAIL enmed_pending got fin=%b dir=%b want fin=1 dir=%b", fin, interface_direction, cur_dir); end
        enable = 1'b1; medir = 1'b1; tick(); enable = 1'b0; medir = 1'b0;
        cur_dir = 2'b11;
        total++; if (interface_direction !== cur_dir) begin bad++; $display("FAIL enmed_dir got %b want %b", interface_direction, cur_dir); end
        total++; if (db_state !== 4'd1 || trigger_left !== 1'b1 || fim_inter !== 1'b0) begin bad++; $display("FAIL enmed_restart got st=%0d tl=%b fim=%b want st=1 tl=1 fim=0", db_state, trigger_left, fim_inter); end
        clear = 1'b1; tick(); clear = 1'b0;
        total++; if (db_state !== 4'd0 || trigger_left !== 1'b0 || interface_direction !== cur_dir) begin bad++; $display("FAIL enmed_clear got st=%0d tl=%b dir=%b want st=0 tl=0 dir=%b", db_state, trigger_left, interface_direction, cur_dir); end
    endtask

    task automatic test_clear_abort();
        int tl, gl, wl; bit fin;
        run_meas(1, 10, 1, 30, 1'b1, 1'b1, tl, gl, wl, fin);
        total++; if (tl != TRIG) begin bad++; $display("FAIL abort_trig_not_extended got %0d want %0d", tl, TRIG); end
        total++; if (db_state !== 4'd0 || fim_inter !== 1'b0 || trigger_right !== 1'b0) begin bad++; $display("FAIL abort_state got st=%0d fim=%b tr=%b want st=0 fim=0 tr=0", db_state, fim_inter, trigger_right); end
        total++; if (interface_direction !== cur_dir) begin bad++; $display("FAIL abort_dir_held got %b want %b", interface_direction, cur_dir); end
        enable = 1'b1; tick(); enable = 1'b0; tick();
        total++; if (interface_direction !== cur_dir || db_state !== 4'd0) begin bad++; $display("FAIL abort_enable_idle got dir=%b st=%0d want dir=%b st=0", interface_direction, db_state, cur_dir); end
    endtask

    task automatic test_random();
        int tl, gl, wl, dl, wdl, dr, wdr; bit fin, nl, nr, tol, tor;
        for (int i = 0; i < 8; i++) begin
            dl = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 20));
            wdl = int'($urandom_range(1, 60));
            dr = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 20));
            wdr = int'($urandom_range(1, 60));
            model(dl, wdl, nl, tol);
            model(dr, wdr, nr, tor);
            run_meas(dl, wdl, dr, wdr, 1'b0, 1'b0, tl, gl, wl, fin);
            enable = 1'b1; tick(); enable = 1'b0;
            if (fin) cur_dir = {nr, nl};
            total++;
            if (fin !== 1'b1 || interface_direction !== {nr, nl} || timeout !== (tol | tor)) begin
                bad++;
                $display("FAIL rand_%0d dl=%0d wl=%0d dr=%0d wr=%0d got fin=%b dir=%b to=%b want fin=1 dir=%b to=%b",
                         i, dl, wdl, dr, wdr, fin, interface_direction, timeout, {nr, nl}, tol | tor);
            end
        end
    endtask

    task automatic test_async_reset();
        medir = 1'b1; tick(); medir = 1'b0;
        tick();
        #2 reset = 1'b0;
        #1;
        total++;
        if (trigger_left !== 1'b0 || db_state !== 4'd0 || interface_direction !== 2'b00) begin
            bad++;
            $display("FAIL async_reset got tl=%b st=%0d dir=%b want tl=0 st=0 dir=00", trigger_left, db_state, interface_direction);
        end
        tick();
        reset = 1'b1;
        cur_dir = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_left_no_echo();
        test_left_stuck();
        test_boundary();
        test_enable_medir();
        test_clear_abort();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
